// File: rtl/mutation_sched_if.sv
// Lane-side and engine-side signal bundle of the mutation scheduler.
// slave: the scheduler's view; master: the GA core lanes plus the mutation engine.
interface mutation_sched_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned GENE_LEN   = 12,
    parameter int unsigned CHAR_WIDTH = 8
);
    logic [NUM_REQ-1:0]                     req;
    logic [NUM_REQ*GENE_LEN*CHAR_WIDTH-1:0] child_bus;
    logic [NUM_REQ*8-1:0]                   thresh_bus;
    logic [NUM_REQ-1:0]                     gnt;
    logic [NUM_REQ-1:0]                     res_valid;
    logic [NUM_REQ-1:0]                     res_ready;
    logic [GENE_LEN*CHAR_WIDTH-1:0]         res_data;
    logic                                   res_err;
    logic                                   mut_start;
    logic [GENE_LEN*CHAR_WIDTH-1:0]         mut_child;
    logic [GENE_LEN*8-1:0]                  mut_rand_mask;
    logic [GENE_LEN*8-1:0]                  mut_rand_ascii;
    logic [7:0]                             mut_thresh;
    logic [GENE_LEN*CHAR_WIDTH-1:0]         mut_mutant;
    logic                                   mut_done;

    modport slave (
        input  req, child_bus, thresh_bus, res_ready, mut_mutant, mut_done,
        output gnt, res_valid, res_data, res_err,
               mut_start, mut_child, mut_rand_mask, mut_rand_ascii, mut_thresh
    );

    modport master (
        output req, child_bus, thresh_bus, res_ready, mut_mutant, mut_done,
        input  gnt, res_valid, res_data, res_err,
               mut_start, mut_child, mut_rand_mask, mut_rand_ascii, mut_thresh
    );
endinterface

// File: rtl/mutation_sched.sv
// Round-robin share of one mutation engine among NUM_REQ lanes, with LFSR byte fill and done watchdog.
// Optional MUT_PRINTABLE_EN: ASCII bytes mapped into the printable range 32..126.
module mutation_sched #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned GENE_LEN   = 12,
    parameter int unsigned CHAR_WIDTH = 8,
    parameter logic [31:0] SEED       = 32'hACE1_2024,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic            clk,
    input logic            rst,
    mutation_sched_if.slave bus
);
    localparam int unsigned IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned GW        = GENE_LEN * CHAR_WIDTH;
    localparam int unsigned FILL_N    = 2 * GENE_LEN;
    localparam int unsigned K_W       = $clog2(FILL_N);
    localparam int unsigned WD_W      = 16;
    localparam logic [31:0] POLY      = 32'h8020_0003;
    localparam logic [31:0] LFSR_INIT = (SEED == 32'd0) ? 32'd1 : SEED;

    typedef enum logic [2:0] {IDLE, FILL, START, WAIT, DELIVER} state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] idx;
    logic [K_W-1:0]   k;
    logic [WD_W-1:0]  wd;
    logic [31:0]      lfsr;
    logic [31:0]      lfsr_nxt;
    logic [7:0]       fill_byte;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;
    logic             win_found;

    // Eight Galois right-shift steps per fill cycle
    function automatic logic [31:0] step8(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        return r;
    endfunction

    always_comb lfsr_nxt = step8(lfsr);

    always_comb begin
`ifdef MUT_PRINTABLE_EN
        if (k >= K_W'(GENE_LEN))
            fill_byte = 8'd32 + {2'b00, lfsr_nxt[5:0]} + (lfsr_nxt[6] ? 8'd31 : 8'd0);
        else
            fill_byte = lfsr_nxt[7:0];
`else
        fill_byte = lfsr_nxt[7:0];
`endif
    end

    // First requester at or after rr_ptr, circularly
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            rr_ptr             <= '0;
            idx                <= '0;
            k                  <= '0;
            wd                 <= '0;
            lfsr               <= LFSR_INIT;
            bus.gnt            <= '0;
            bus.res_valid      <= '0;
            bus.res_data       <= '0;
            bus.res_err        <= 1'b0;
            bus.mut_start      <= 1'b0;
            bus.mut_child      <= '0;
            bus.mut_thresh     <= '0;
            bus.mut_rand_mask  <= '0;
            bus.mut_rand_ascii <= '0;
        end else begin
            bus.gnt       <= '0;
            bus.mut_start <= 1'b0;
            case (state)
                IDLE: if (win_found) begin
                    idx            <= win_idx;
                    bus.gnt        <= NUM_REQ'(1) << win_idx;
                    bus.mut_child  <= bus.child_bus[win_idx*GW +: GW];
                    bus.mut_thresh <= bus.thresh_bus[win_idx*8 +: 8];
                    k              <= '0;
                    state          <= FILL;
                end
                FILL: begin
                    lfsr <= lfsr_nxt;
                    if (k < K_W'(GENE_LEN)) bus.mut_rand_mask[k*8 +: 8] <= fill_byte;
                    else bus.mut_rand_ascii[(k - K_W'(GENE_LEN))*8 +: 8] <= fill_byte;
                    if (k == K_W'(FILL_N - 1)) begin
                        bus.mut_start <= 1'b1;
                        state         <= START;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                START: begin
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: if (bus.mut_done) begin
                    bus.res_data  <= bus.mut_mutant;
                    bus.res_err   <= 1'b0;
                    bus.res_valid <= NUM_REQ'(1) << idx;
                    state         <= DELIVER;
                end else if (wd == WD_W'(TIMEOUT - 1)) begin
                    // Engine never answered: hand the untouched child back flagged as error
                    bus.res_data  <= bus.mut_child;
                    bus.res_err   <= 1'b1;
                    bus.res_valid <= NUM_REQ'(1) << idx;
                    state         <= DELIVER;
                end else begin
                    wd <= wd + 1'b1;
                end
                DELIVER: if (bus.res_ready[idx]) begin
                    bus.res_valid <= '0;
                    bus.res_err   <= 1'b0;
                    rr_ptr        <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mutation_sched.sv
// Scoreboard bench for mutation_sched: reference model predicts grant order, LFSR bytes and results.
module tb_mutation_sched;
    localparam int unsigned NR   = 4;
    localparam int unsigned G    = 12;
    localparam int unsigned CW   = 8;
    localparam int unsigned TO   = 255;
    localparam int unsigned GW   = G * CW;
    localparam logic [31:0] SEED = 32'hACE1_2024;
    localparam logic [31:0] POLY = 32'h8020_0003;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mutation_sched_if #(.NUM_REQ(NR), .GENE_LEN(G), .CHAR_WIDTH(CW)) bus ();

    mutation_sched #(.NUM_REQ(NR), .GENE_LEN(G), .CHAR_WIDTH(CW), .SEED(SEED), .TIMEOUT(TO))
        dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int            lane;
        logic [GW-1:0] child;
        logic [7:0]    thr;
        logic [G*8-1:0] mask;
        logic [G*8-1:0] ascii;
        logic [GW-1:0] data;
        bit            err;
        int            delay;
        bit            hang;
        bit            started;
        bit            seen;
        int            t_start;
    } job_t;

    job_t          q[$];
    int            gnt_log[$];
    logic [GW-1:0] lane_child[NR];
    logic [7:0]    lane_thr[NR];
    int            lane_delay[NR];
    bit            lane_hang[NR];
    logic [NR-1:0] pend     = '0;
    logic [NR-1:0] prev_req = '0;
    bit            hold_req = 1'b0;
    bit            ready_rand = 1'b0;
    logic          ready_val  = 1'b1;
    bit            busy = 1'b0;
    int            ptr  = 0;
    logic [31:0]   m_lfsr = SEED;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_fail = 0;

    // Model LFSR: one new byte = eight shift-right steps, poly folded in when an odd value shifts out
    function automatic logic [31:0] adv(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < 8; i++) r = (r / 2) ^ ((r % 2 == 1) ? POLY : 32'd0);
        return r;
    endfunction

    function automatic logic [7:0] to_ascii(input logic [7:0] r);
`ifdef MUT_PRINTABLE_EN
        return 8'(32 + (r % 64) + ((r / 64) % 2) * 31);
`else
        return r;
`endif
    endfunction

    // Stand-in engine rule: replace a character when its mask byte is below the threshold (255 = always)
    function automatic bit mutate(input logic [7:0] m, input logic [7:0] t);
        return (t == 8'hFF) || (m < t);
    endfunction

    function automatic logic [GW-1:0] rnd_child();
        logic [GW-1:0] r;
        for (int i = 0; i < G; i++) r[i*8 +: 8] = 8'($urandom_range(0, 255));
        return r;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got event count exceeded, expected bounded completion", nm);
    endtask

    task automatic check_outputs_zero(input string nm);
        check({nm, "_gnt"},       128'(bus.gnt),            128'(0));
        check({nm, "_res_valid"}, 128'(bus.res_valid),      128'(0));
        check({nm, "_res_err"},   128'(bus.res_err),        128'(0));
        check({nm, "_mut_start"}, 128'(bus.mut_start),      128'(0));
        check({nm, "_mut_child"}, 128'(bus.mut_child),      128'(0));
        check({nm, "_mut_thr"},   128'(bus.mut_thresh),     128'(0));
        check({nm, "_mask"},      128'(bus.mut_rand_mask),  128'(0));
        check({nm, "_ascii"},     128'(bus.mut_rand_ascii), 128'(0));
        check({nm, "_res_data"},  128'(bus.res_data),       128'(0));
    endtask

    task automatic model_reset();
        q.delete();
        busy     = 1'b0;
        ptr      = 0;
        m_lfsr   = SEED;
        pend     = '0;
        prev_req = '0;
    endtask

    task automatic apply_reset(input string nm);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_outputs_zero(nm);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic issue(input int l, input logic [GW-1:0] c, input logic [7:0] t,
                         input int d, input bit h);
        @(posedge clk); #1;
        lane_child[l] = c;
        lane_thr[l]   = t;
        lane_delay[l] = d;
        lane_hang[l]  = h;
        bus.child_bus[l*GW +: GW] = c;
        bus.thresh_bus[l*8 +: 8]  = t;
        pend[l] = 1'b1;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n;
        n = 0;
        while ((pend != '0 || q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) fail_now(nm);
        @(negedge clk);
    endtask

    // Lane request / ready drivers
    initial begin : drv
        bus.req       = '0;
        bus.res_ready = '0;
        forever begin
            @(posedge clk); #1;
            bus.req       = pend;
            bus.res_ready = ready_rand ? NR'($urandom_range(0, 15)) : {NR{ready_val}};
        end
    end

    // Engine stand-in: answers mut_start after the job's delay unless the job is meant to hang
    initial begin : engine
        logic [GW-1:0] m;
        int d;
        bus.mut_done   = 1'b0;
        bus.mut_mutant = '0;
        forever begin
            @(negedge clk);
            if (bus.mut_start && !rst && q.size() > 0 && !q[0].hang) begin
                for (int i = 0; i < G; i++)
                    m[i*8 +: 8] = mutate(bus.mut_rand_mask[i*8 +: 8], bus.mut_thresh) ?
                                  bus.mut_rand_ascii[i*8 +: 8] : bus.mut_child[i*8 +: 8];
                d = q[0].delay;
                repeat (d) @(posedge clk);
                #1;
                bus.mut_done   = 1'b1;
                bus.mut_mutant = m;
                @(posedge clk); #1;
                bus.mut_done   = 1'b0;
                bus.mut_mutant = '0;
            end
        end
    end

    // Monitor: predicts each grant, checks engine-side bytes and every delivered result
    always @(negedge clk) begin : mon
        job_t j;
        int   w;
        cyc++;
        if (!rst) begin
            if (bus.gnt != '0) begin
                w = -1;
                for (int i = 0; i < NR; i++)
                    if (w < 0 && prev_req[(ptr + i) % NR]) w = (ptr + i) % NR;
                gnt_log.push_back($clog2(bus.gnt));
                if (busy || w < 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL gnt_unexpected: got %b expected no grant", bus.gnt);
                end else begin
                    check("gnt_lane", 128'(bus.gnt), 128'(NR'(1) << w));
                    j.lane = w; j.child = lane_child[w]; j.thr = lane_thr[w];
                    j.delay = lane_delay[w]; j.hang = lane_hang[w];
                    j.started = 1'b0; j.seen = 1'b0; j.t_start = 0;
                    for (int b = 0; b < 2 * G; b++) begin
                        m_lfsr = adv(m_lfsr);
                        if (b < G) j.mask[b*8 +: 8] = m_lfsr[7:0];
                        else j.ascii[(b-G)*8 +: 8] = to_ascii(m_lfsr[7:0]);
                    end
                    for (int i = 0; i < G; i++)
                        j.data[i*8 +: 8] = (!j.hang && mutate(j.mask[i*8 +: 8], j.thr)) ?
                                           j.ascii[i*8 +: 8] : j.child[i*8 +: 8];
                    j.err = j.hang;
                    q.push_back(j);
                    busy = 1'b1;
                    if (!hold_req) pend[w] = 1'b0;
                end
            end
            if (bus.mut_start) begin
                if (q.size() == 0 || q[0].started) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL start_unexpected: got mut_start=1 expected 0");
                end else begin
                    check("mut_mask",  128'(bus.mut_rand_mask),  128'(q[0].mask));
                    check("mut_ascii", 128'(bus.mut_rand_ascii), 128'(q[0].ascii));
                    check("mut_child", 128'(bus.mut_child),      128'(q[0].child));
                    check("mut_thr",   128'(bus.mut_thresh),     128'(q[0].thr));
`ifdef MUT_PRINTABLE_EN
                    for (int i = 0; i < G; i++)
                        check("ascii_range", 128'(bus.mut_rand_ascii[i*8 +: 8] >= 8'd32 &&
                                                  bus.mut_rand_ascii[i*8 +: 8] <= 8'd126), 128'(1));
`endif
                    q[0].started = 1'b1;
                    q[0].t_start = cyc;
                end
            end
            if (bus.res_valid != '0) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL res_unexpected: got res_valid=%b expected 0", bus.res_valid);
                end else begin
                    if (!q[0].seen) begin
                        q[0].seen = 1'b1;
                        check("start_seen", 128'(q[0].started), 128'(1));
                        check("latency", 128'(cyc - q[0].t_start),
                              128'(q[0].hang ? int'(TO) + 1 : q[0].delay + 1));
                    end
                    check("res_valid", 128'(bus.res_valid), 128'(NR'(1) << q[0].lane));
                    check("res_data",  128'(bus.res_data),  128'(q[0].data));
                    check("res_err",   128'(bus.res_err),   128'(q[0].err));
                    if ((bus.res_valid & bus.res_ready) != '0) begin
                        ptr  = (q[0].lane + 1) % NR;
                        busy = 1'b0;
                        void'(q.pop_front());
                    end
                end
            end
        end
        prev_req = bus.req;
    end

    initial begin : main
        int exp_order[6];
        int gbase;
        int n;
        int l;
        exp_order = '{0, 1, 2, 3, 0, 1};
        bus.child_bus  = '0;
        bus.thresh_bus = '0;
        for (int i = 0; i < NR; i++) begin
            lane_child[i] = '0; lane_thr[i] = '0; lane_delay[i] = 1; lane_hang[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // First job after reset: thresh 255 takes every ASCII byte from the seed sequence
        issue(0, rnd_child(), 8'hFF, 3, 1'b0);
        wait_idle(500, "t2_idle");
        issue(0, GW'("HELLO WORLD!"), 8'h00, 14, 1'b0);
        wait_idle(500, "t1_idle");

        // All lanes held requesting from a fresh pointer
        apply_reset("idle_reset");
        gbase = gnt_log.size();
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) begin
            lane_child[i] = rnd_child(); lane_thr[i] = 8'($urandom_range(0, 255));
            lane_delay[i] = 2; lane_hang[i] = 1'b0;
            bus.child_bus[i*GW +: GW] = lane_child[i];
            bus.thresh_bus[i*8 +: 8]  = lane_thr[i];
        end
        hold_req = 1'b1;
        pend     = '1;
        n = 0;
        while (gnt_log.size() < gbase + 6 && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) fail_now("t3_grants");
        @(posedge clk); #1;
        pend     = '0;
        hold_req = 1'b0;
        wait_idle(500, "t3_idle");
        for (int i = 0; i < 6; i++)
            if (gnt_log.size() > gbase + i)
                check("t3_order", 128'(gnt_log[gbase + i]), 128'(exp_order[i]));

        // Engine never answers
        issue(2, rnd_child(), 8'h80, 1, 1'b1);
        wait_idle(600, "t4_idle");

        // Result held while the lane stalls, another lane waiting
        ready_val = 1'b0;
        issue(1, rnd_child(), 8'h40, 5, 1'b0);
        n = 0;
        while (bus.res_valid == '0 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) fail_now("t5_valid");
        issue(3, rnd_child(), 8'hC0, 2, 1'b0);
        repeat (10) @(negedge clk);
        check("t5_no_gnt", 128'(bus.gnt), 128'(0));
        ready_val = 1'b1;
        wait_idle(500, "t5_idle");

        // Randomised traffic with random back-pressure
        ready_rand = 1'b1;
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 6)) @(posedge clk);
            l = $urandom_range(0, NR - 1);
            if (!pend[l])
                issue(l, rnd_child(), 8'($urandom_range(0, 255)), $urandom_range(1, 20),
                      $urandom_range(0, 9) == 0);
        end
        wait_idle(20000, "rand_idle");
        ready_rand = 1'b0;
        ready_val  = 1'b1;

        // Reset in the middle of WAIT, then a fresh job from the seed
        issue(0, rnd_child(), 8'h80, 1, 1'b1);
        n = 0;
        while (!(q.size() > 0 && q[0].started) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) fail_now("t6_start");
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_outputs_zero("t6");
        @(posedge clk); #1;
        rst = 1'b0;
        issue(2, rnd_child(), 8'hFF, 4, 1'b0);
        wait_idle(500, "t6_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
